// File: rtl/icache_ro_dm.sv
// icache_ro_dm: direct-mapped, read-only instruction cache.
// Hits return data combinationally in the same cycle. A miss stalls the fetch
// stage while the whole 128-bit line is fetched from instruction memory.
// Optional build macro ICACHE_PERF_CNT_EN adds the hit_cnt/miss_cnt outputs.
module icache_ro_dm #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 28 - IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  typedef enum logic [0:0] {IDLE, ALLOC} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
  logic [27:0]            miss_q, miss_d;
  logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
  logic [127:0]           data_q [NUM_BLOCKS];

  logic [IDX_W-1:0]       idx, miss_idx;
  logic [TAG_W-1:0]       tag, miss_tag;
  logic [1:0]             off;
  logic                   hit, fill_en, hit_evt, miss_evt;

  // The cache never writes; these inputs are intentionally dropped.
  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

  assign idx      = proc_addr[IDX_W+1:2];
  assign tag      = proc_addr[29:IDX_W+2];
  assign off      = proc_addr[1:0];
  assign miss_idx = miss_q[IDX_W-1:0];
  assign miss_tag = miss_q[27:IDX_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign mem_addr  = miss_q;

  // Next-state and handshake outputs; ALLOC ignores proc_* entirely.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    miss_d     = miss_q;
    fill_en    = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    case (state_q)
      IDLE: begin
        if (proc_read) begin
          if (hit) begin
            proc_rdata = data_q[idx][{off, 5'b0} +: 32];
            hit_evt    = 1'b1;
          end else begin
            proc_stall = 1'b1;
            miss_d     = proc_addr[29:2];
            miss_evt   = 1'b1;
            state_d    = ALLOC;
          end
        end
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          fill_en           = 1'b1;
          valid_d[miss_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, valid bits and the latched miss line address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
    end
  end

  // Tag/data arrays need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'd0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_evt};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_evts;
  assign unused_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache_ro_dm.sv
// Directed testbench for icache_ro_dm. Memory model answers 3 cycles after
// mem_read rises; word k of line L is {L, k[1:0], 2'b01}, so the word for
// word address A is {A, 2'b01}.
module tb_icache_ro_dm;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall, mem_read, mem_write;
  logic [31:0]  proc_rdata;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int n_vec = 0, n_bad = 0;
  int mcnt = 0;

  icache_ro_dm dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: pulses mem_ready on the 3rd cycle of a held mem_read.
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt      = 0;
      mem_ready = 1'b0;
    end else if (mem_read && !mem_ready) begin
      mcnt = mcnt + 1;
      if (mcnt == 3) begin
        for (int k = 0; k < 4; k++) mem_rdata[32*k +: 32] = {mem_addr, k[1:0], 2'b01};
        mem_ready = 1'b1;
        mcnt      = 0;
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    proc_read = 1'b0;
    proc_write = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue a read at the next negedge and wait (bounded) for the stall to drop.
  task automatic fetch(input logic [29:0] a, output bit missed, output int ncyc,
                       output logic [27:0] maddr);
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = a;
    #1;
    missed = proc_stall;
    ncyc   = 0;
    maddr  = '0;
    while (proc_stall && ncyc < 50) begin
      if (mem_read) maddr = mem_addr;
      @(negedge clk);
      #1;
      ncyc++;
    end
    chk("stall_release", {127'd0, proc_stall}, 128'd0);
  endtask

  bit          missed;
  int          ncyc;
  logic [27:0] maddr;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {127'd0, proc_stall}, 128'd0);
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    chk("rst_rdata", {96'd0, proc_rdata}, 128'd0);
    chk("mem_write", {127'd0, mem_write}, 128'd0);
    chk("mem_wdata", mem_wdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss on word 1 of line 0
    fetch(30'h1, missed, ncyc, maddr);
    chk("cold_missed", {127'd0, missed}, 128'd1);
    chk("cold_stall_cycles", 128'(ncyc), 128'd4);
    chk("cold_mem_addr", {100'd0, maddr}, 128'd0);
    chk("cold_rdata", {96'd0, proc_rdata}, 128'h5);
`ifdef ICACHE_PERF_CNT_EN
    chk("miss_cnt", {96'd0, miss_cnt}, 128'd1);
    @(posedge clk);
    #1;
    chk("hit_cnt", {96'd0, hit_cnt}, 128'd1);
`endif

    // Line hits on words 0, 2, 3
    fetch(30'h0, missed, ncyc, maddr);
    chk("hit0_missed", {127'd0, missed}, 128'd0);
    chk("hit0_mem_read", {127'd0, mem_read}, 128'd0);
    chk("hit0_rdata", {96'd0, proc_rdata}, 128'h1);
    fetch(30'h2, missed, ncyc, maddr);
    chk("hit2_missed", {127'd0, missed}, 128'd0);
    chk("hit2_rdata", {96'd0, proc_rdata}, 128'h9);
    fetch(30'h3, missed, ncyc, maddr);
    chk("hit3_missed", {127'd0, missed}, 128'd0);
    chk("hit3_mem_read", {127'd0, mem_read}, 128'd0);
    chk("hit3_rdata", {96'd0, proc_rdata}, 128'hD);

    // Conflict eviction on index 0
    pulse_reset();
    fetch(30'h0, missed, ncyc, maddr);
    chk("conf_a_missed", {127'd0, missed}, 128'd1);
    chk("conf_a_addr", {100'd0, maddr}, 128'h0);
    fetch(30'h20, missed, ncyc, maddr);
    chk("conf_b_missed", {127'd0, missed}, 128'd1);
    chk("conf_b_addr", {100'd0, maddr}, 128'h8);
    chk("conf_b_rdata", {96'd0, proc_rdata}, 128'h81);
    fetch(30'h0, missed, ncyc, maddr);
    chk("conf_c_missed", {127'd0, missed}, 128'd1);
    chk("conf_c_addr", {100'd0, maddr}, 128'h0);
    chk("conf_c_rdata", {96'd0, proc_rdata}, 128'h1);

    // Address change during ALLOC
    pulse_reset();
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    chk("chg_first_stall", {127'd0, proc_stall}, 128'd1);
    @(negedge clk);
    proc_addr = 30'h40;
    #1;
    chk("chg_mem_addr_a", {100'd0, mem_addr}, 128'h4);
    @(negedge clk);
    #1;
    chk("chg_mem_addr_b", {100'd0, mem_addr}, 128'h4);
    @(negedge clk);
    #1;
    chk("chg_mem_ready", {127'd0, mem_ready}, 128'd1);
    chk("chg_mem_addr_c", {100'd0, mem_addr}, 128'h4);
    @(negedge clk);
    #1;
    // Back in IDLE with 30'h40 presented: fresh miss
    chk("chg_new_miss", {127'd0, proc_stall}, 128'd1);
    @(negedge clk);
    #1;
    chk("chg_new_addr", {100'd0, mem_addr}, 128'h10);
    repeat (3) @(negedge clk);
    #1;
    chk("chg_40_rdata", {96'd0, proc_rdata}, 128'h101);
    fetch(30'h10, missed, ncyc, maddr);
    chk("chg_10_hit", {127'd0, missed}, 128'd0);
    chk("chg_10_rdata", {96'd0, proc_rdata}, 128'h41);

    // Async reset in the middle of a fill
    pulse_reset();
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h10;
    @(negedge clk);
    #1;
    chk("ar_mem_read_before", {127'd0, mem_read}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_read_now", {127'd0, mem_read}, 128'd0);
    chk("ar_mem_addr_now", {100'd0, mem_addr}, 128'd0);
    proc_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch(30'h10, missed, ncyc, maddr);
    chk("ar_remiss", {127'd0, missed}, 128'd1);
    chk("ar_remiss_addr", {100'd0, maddr}, 128'h4);
    chk("ar_rdata", {96'd0, proc_rdata}, 128'h41);

    // Writes are ignored
    @(negedge clk);
    proc_read = 1'b0;
    proc_write = 1'b1;
    proc_addr = 30'h2A5;
    proc_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_stall", {127'd0, proc_stall}, 128'd0);
    @(negedge clk);
    #1;
    chk("wr_mem_read", {127'd0, mem_read}, 128'd0);
    chk("wr_stall2", {127'd0, proc_stall}, 128'd0);
    fetch(30'h10, missed, ncyc, maddr);
    chk("wr_rd_hit", {127'd0, missed}, 128'd0);
    chk("wr_rd_rdata", {96'd0, proc_rdata}, 128'h41);
    proc_write = 1'b0;

    // Address wrap: last word of last line
    fetch(30'h3FFF_FFFF, missed, ncyc, maddr);
    chk("wrap_missed", {127'd0, missed}, 128'd1);
    chk("wrap_addr", {100'd0, maddr}, 128'hFFF_FFFF);
    chk("wrap_rdata", {96'd0, proc_rdata}, 128'hFFFF_FFFD);

    @(negedge clk);
    proc_read = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_ro_dm.md
Name: icache_ro_dm

Overview:
- Direct-mapped, read-only instruction cache.
- Responder on the processor-side ICACHE interface driven by the fetch stage: word address, read enable, stall back.
- Initiator on the block-granular instruction-memory interface: 128-bit lines, mem_ready handshake.
- Sits between the IF stage and instruction memory; the processor is stalled only on misses.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two, >= 2.
- IDX_W, 3, log2(NUM_BLOCKS); index width.
- TAG_W, 25, tag width = 28 - IDX_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- proc_read  input  1  fetch request.
- proc_write  input  1  write request; ignored, the cache is read-only.
- proc_addr  input  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  input  32  unused.
- proc_stall  output  1  high while the request cannot complete this cycle.
- proc_rdata  output  32  fetched word; valid when proc_read=1 and proc_stall=0.
- mem_read  output  1  line fetch request; held until mem_ready.
- mem_write  output  1  constant 0.
- mem_addr  output  28  line address = proc_addr[29:2] captured at the miss.
- mem_wdata  output  128  constant 0.
- mem_rdata  input  128  fill line; word k at bits [32k+31:32k].
- mem_ready  input  1  one-cycle pulse; mem_rdata valid in the same cycle.

Behaviour:
- Storage per line: valid bit, TAG_W tag, 128-bit data.
- Reset (async, rst_n=0):
  - All valid bits cleared; state=IDLE.
  - mem_read=0, mem_addr=0, proc_stall=0, proc_rdata=0.
  - Tag and data arrays are not required to be reset.
- Hit test (combinational): hit = valid[idx] & (tag[idx] == proc_addr tag).
- State IDLE:
  - proc_read=1 & hit: proc_stall=0; proc_rdata = word[offset] of line[idx]. Zero-latency hit.
  - proc_read=1 & miss: proc_stall=1 in the same cycle. Latch proc_addr[29:2] into the miss register and go to ALLOC.
  - proc_read=0: proc_stall=0; proc_rdata=0; no state change.
- State ALLOC:
  - mem_read=1 and mem_addr = miss register; proc_stall=1 unconditionally.
  - proc_addr and proc_read changes are ignored; the fill always completes to the latched address.
  - When mem_ready=1: write mem_rdata into line[miss idx], set tag and valid, go to IDLE.
- Miss penalty:
  - The original request is re-evaluated in IDLE the cycle after mem_ready and hits, provided proc_addr is unchanged.
  - Total stall = memory latency + 1 cycles.
- Refills replace the indexed line unconditionally; no dirty state and no write-back.
- proc_write=1 never stalls and never modifies state. If proc_read=1 as well, the read is serviced normally.
- mem_ready while IDLE is ignored.
- Async reset during ALLOC aborts the fill; the line stays invalid. The memory model is reset concurrently.
- Address wrap: index and tag are pure bit fields; 30'h3FFFFFFF maps to the last word of the last line with no special case.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt [31:0] and miss_cnt [31:0], both reset to 0.
  - hit_cnt increments once per IDLE cycle with proc_read & hit.
  - miss_cnt increments once per IDLE->ALLOC transition.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, proc_read=1, proc_addr=30'h0000_0001; memory answers 3 cycles after mem_read.
  - Required: proc_stall=1 for 4 cycles; mem_addr=28'h0; then proc_rdata = mem_rdata[63:32] with stall=0.
- Line hit:
  - Stimulus: same line filled, then proc_addr = 0, 2, 3 on consecutive cycles.
  - Required: stall=0 every cycle; words 0, 2, 3 of the line returned; mem_read stays 0.
- Conflict eviction (NUM_BLOCKS=8):
  - Stimulus: fetch 30'h0000_0000, then 30'h0000_0020 (same index 0, tag 1), then 30'h0000_0000.
  - Required: three misses; mem_addr = 28'h0, 28'h8, 28'h0 in turn.
- Address change during ALLOC:
  - Stimulus: miss on 30'h10; during ALLOC switch proc_addr to 30'h40.
  - Required: mem_addr stays 28'h4; line for 30'h10 filled; then a fresh miss with mem_addr=28'h10.
- Async reset during ALLOC:
  - Stimulus: rst_n low mid-miss on 30'h10, without a clock edge.
  - Required: mem_read=0 immediately; after release, fetch of 30'h10 misses again.
- Write ignored and counters:
  - Stimulus: proc_write=1 with proc_read=0, any address.
  - Required: stall=0 and no memory traffic.
  - With ICACHE_PERF_CNT_EN defined and the first-scenario flow: miss_cnt=1 and hit_cnt=1 after the stall releases.
